debug_probe_capture: RTL and testbench

//  On-chip logic-analyser probe for CommsFPGA debug: samples a PROBE_W-bit vector of internal

---
 rtl/debug_probe_capture_if.sv | 20 ++
 rtl/debug_probe_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_debug_probe_capture.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/debug_probe_capture_if.sv
// APB3 slave bus bundle for the debug probe capture block (8-bit address/data).
interface debug_probe_capture_if;
    logic       apb3_sel;
    logic       apb3_enable;
    logic       apb3_write;
    logic [7:0] apb3_addr;
    logic [7:0] apb3_wdata;
    logic [7:0] apb3_rdata;
    logic       apb3_ready;

    modport master (
        output apb3_sel, apb3_enable, apb3_write, apb3_addr, apb3_wdata,
        input  apb3_rdata, apb3_ready
    );

    modport slave (
        input  apb3_sel, apb3_enable, apb3_write, apb3_addr, apb3_wdata,
        output apb3_rdata, apb3_ready
    );
endinterface

// File: rtl/debug_probe_capture.sv
// On-chip logic-analyser probe: ring-buffer capture with masked level/edge
// trigger, post-trigger sample count and APB3 register readback.
module debug_probe_capture #(
    parameter int unsigned PROBE_W = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned AW      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PROBE_W-1:0]   probe_data,
    input  logic                 probe_en,
    debug_probe_capture_if.slave apb,
    output logic                 capt_int
);
    localparam int unsigned NB = PROBE_W / 8;
    localparam int unsigned FW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      trig_addr_q, trig_addr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [AW-1:0]      post_act_q, post_act_d;
    logic [AW-1:0]      post_q, post_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PROBE_W-1:0] mask_q, mask_d;
    logic [PROBE_W-1:0] value_q, value_d;
    logic [PROBE_W-1:0] mask_act_q, mask_act_d;
    logic [PROBE_W-1:0] value_act_q, value_act_d;
    logic               edge_q, edge_d;
    logic               edge_act_q, edge_act_d;
    logic               hit_q, hit_d;
    logic               triggered_q, triggered_d;
    logic               capt_int_q, capt_int_d;
    logic               force_pend_q, force_pend_d;
    logic               rd_ready_q, rd_ready_d;
    logic [7:0]         rdata_q, rdata_d;

    logic [PROBE_W-1:0] buf_mem [DEPTH];

    logic               wr_stb_c, rd_first_c, ctrl_wr_c;
    logic               arm_c, abort_c, force_now_c;
    logic               hit_c, trig_c, qual_c, cap_we_c;
    logic [PROBE_W-1:0] rd_word_c;
    logic [7:0]         rd_mux_c;

    // APB strobes and CTRL command decode
    assign wr_stb_c   = apb.apb3_sel & apb.apb3_enable & apb.apb3_write;
    assign rd_first_c = apb.apb3_sel & apb.apb3_enable & ~apb.apb3_write & ~rd_ready_q;
    assign ctrl_wr_c  = wr_stb_c & (apb.apb3_addr == 8'h00);
    assign abort_c    = ctrl_wr_c & apb.apb3_wdata[1];
    assign arm_c      = ctrl_wr_c & apb.apb3_wdata[0] & ~apb.apb3_wdata[1];
    assign force_now_c = force_pend_q | (ctrl_wr_c & apb.apb3_wdata[3]);

    // Trigger match against the configuration latched at ARM
    assign hit_c  = (((probe_data ^ value_act_q) & mask_act_q) == '0);
    assign trig_c = edge_act_q ? (hit_c & ~hit_q) : hit_c;
    assign qual_c = (fill_q >= (FW'(DEPTH - 1) - FW'(post_act_q)));

    assign apb.apb3_ready = apb.apb3_sel & apb.apb3_enable & (apb.apb3_write | rd_ready_q);
    assign apb.apb3_rdata = rdata_q;
    assign capt_int       = capt_int_q;

    // Buffer word for readback; a same-cycle capture into RD_PTR is seen first
    assign rd_word_c = (cap_we_c && (wr_ptr_q == rd_ptr_q)) ? probe_data : buf_mem[rd_ptr_q];

    // Register read mux
    always_comb begin
        rd_mux_c = 8'h00;
        case (apb.apb3_addr)
            8'h01:   rd_mux_c = {4'b0000, capt_int_q, triggered_q, state_q};
            8'h02:   rd_mux_c = 8'(post_cnt_q);
            8'h03:   rd_mux_c = 8'(trig_addr_q);
            8'h04:   rd_mux_c = 8'(rd_ptr_q);
            8'h05:   rd_mux_c = 8'(wr_ptr_q);
            default: rd_mux_c = 8'h00;
        endcase
        for (int i = 0; i < int'(NB); i++) begin
            if (apb.apb3_addr == 8'(32 + i)) rd_mux_c = mask_q[i*8 +: 8];
            if (apb.apb3_addr == 8'(48 + i)) rd_mux_c = value_q[i*8 +: 8];
            if (apb.apb3_addr == 8'(64 + i)) rd_mux_c = rd_word_c[i*8 +: 8];
        end
    end

    // Next-state: register file, capture FSM, APB read pipeline
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        trig_addr_d  = trig_addr_q;
        rd_ptr_d     = rd_ptr_q;
        post_cnt_d   = post_cnt_q;
        post_act_d   = post_act_q;
        post_d       = post_q;
        fill_d       = fill_q;
        mask_d       = mask_q;
        value_d      = value_q;
        mask_act_d   = mask_act_q;
        value_act_d  = value_act_q;
        edge_d       = edge_q;
        edge_act_d   = edge_act_q;
        hit_d        = hit_q;
        triggered_d  = triggered_q;
        capt_int_d   = capt_int_q;
        force_pend_d = force_pend_q;
        rd_ready_d   = rd_first_c;
        rdata_d      = rd_first_c ? rd_mux_c : rdata_q;
        cap_we_c     = 1'b0;

        if (wr_stb_c) begin
            case (apb.apb3_addr)
                8'h00:   edge_d     = apb.apb3_wdata[2];
                8'h01:   if (apb.apb3_wdata[3]) capt_int_d = 1'b0;
                8'h02:   post_cnt_d = AW'(apb.apb3_wdata);
                8'h04:   rd_ptr_d   = AW'(apb.apb3_wdata);
                default: ;
            endcase
            for (int i = 0; i < int'(NB); i++) begin
                if (apb.apb3_addr == 8'(32 + i)) mask_d[i*8 +: 8]  = apb.apb3_wdata;
                if (apb.apb3_addr == 8'(48 + i)) value_d[i*8 +: 8] = apb.apb3_wdata;
            end
        end

        if (abort_c) begin
            state_d      = S_IDLE;
            force_pend_d = 1'b0;
        end else if (arm_c) begin
            state_d      = S_ARMED;
            wr_ptr_d     = '0;
            fill_d       = '0;
            triggered_d  = 1'b0;
            capt_int_d   = 1'b0;
            hit_d        = 1'b0;
            force_pend_d = 1'b0;
            post_act_d   = post_cnt_q;
            mask_act_d   = mask_q;
            value_act_d  = value_q;
            edge_act_d   = apb.apb3_wdata[2];
        end else begin
            if (probe_en) hit_d = hit_c;
            case (state_q)
                S_ARMED: begin
                    if (probe_en) begin
                        cap_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
                        if ((trig_c && qual_c) || force_now_c) begin
                            trig_addr_d  = wr_ptr_q;
                            triggered_d  = 1'b1;
                            post_d       = post_act_q;
                            force_pend_d = 1'b0;
                            if (post_act_q == '0) begin
                                state_d    = S_DONE;
                                capt_int_d = 1'b1;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end else if (force_now_c) begin
                        force_pend_d = 1'b1;
                    end
                end
                S_POST: begin
                    if (probe_en) begin
                        cap_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        post_d   = post_q - AW'(1);
                        if (post_q == AW'(1)) begin
                            state_d    = S_DONE;
                            capt_int_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            rd_ptr_q     <= '0;
            post_cnt_q   <= '0;
            post_act_q   <= '0;
            post_q       <= '0;
            fill_q       <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            mask_act_q   <= '0;
            value_act_q  <= '0;
            edge_q       <= 1'b0;
            edge_act_q   <= 1'b0;
            hit_q        <= 1'b0;
            triggered_q  <= 1'b0;
            capt_int_q   <= 1'b0;
            force_pend_q <= 1'b0;
            rd_ready_q   <= 1'b0;
            rdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_addr_q  <= trig_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            post_cnt_q   <= post_cnt_d;
            post_act_q   <= post_act_d;
            post_q       <= post_d;
            fill_q       <= fill_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            mask_act_q   <= mask_act_d;
            value_act_q  <= value_act_d;
            edge_q       <= edge_d;
            edge_act_q   <= edge_act_d;
            hit_q        <= hit_d;
            triggered_q  <= triggered_d;
            capt_int_q   <= capt_int_d;
            force_pend_q <= force_pend_d;
            rd_ready_q   <= rd_ready_d;
            rdata_q      <= rdata_d;
        end
    end

    // Sample storage; contents survive reset and abort
    always_ff @(posedge clk) begin
        if (cap_we_c) buf_mem[wr_ptr_q] <= probe_data;
    end
endmodule

// File: tb/tb_debug_probe_capture.sv
// Bench for debug_probe_capture: APB-driven scenarios with a read scoreboard.
module tb_debug_probe_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] probe_data;
    logic        probe_en;
    logic        capt_int;

    debug_probe_capture_if bus ();

    debug_probe_capture #(.PROBE_W(32), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .probe_data (probe_data),
        .probe_en   (probe_en),
        .apb        (bus),
        .capt_int   (capt_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.apb3_sel = 1'b1; bus.apb3_write = 1'b1; bus.apb3_enable = 1'b0;
        bus.apb3_addr = a; bus.apb3_wdata = d;
        @(posedge clk); #1;
        bus.apb3_enable = 1'b1;
        #1 check_eq("wr_ready", 32'(bus.apb3_ready), 32'd1);
        @(posedge clk); #1;
        bus.apb3_sel = 1'b0; bus.apb3_enable = 1'b0; bus.apb3_write = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
        int w;
        w = 0;
        @(posedge clk); #1;
        bus.apb3_sel = 1'b1; bus.apb3_write = 1'b0; bus.apb3_enable = 1'b0;
        bus.apb3_addr = a;
        @(posedge clk); #1;
        bus.apb3_enable = 1'b1;
        #1 check_eq("rd_wait_state", 32'(bus.apb3_ready), 32'd0);
        while (!bus.apb3_ready && w < 4) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("rd_latency", 32'(w), 32'd1);
        d = bus.apb3_rdata;
        bus.apb3_sel = 1'b0; bus.apb3_enable = 1'b0;
    endtask

    // Expected value is queued when the read is issued and retired on completion
    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] m,
                          input logic [7:0] e);
        logic [7:0] d;
        sb_t        s;
        sb_q.push_back('{tag: tag, exp: 32'(e)});
        apb_read(a, d);
        s = sb_q.pop_front();
        check_eq(s.tag, 32'(d & m), s.exp);
    endtask

    task automatic run_probe(input int n, input logic [31:0] v0, input int step, input int en_div);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            probe_data = v0 + 32'(step * i);
            probe_en   = ((i % en_div) == 0);
        end
        @(posedge clk); #1;
        probe_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        probe_data = '0; probe_en = 1'b0;
        bus.apb3_sel = 1'b0; bus.apb3_enable = 1'b0; bus.apb3_write = 1'b0;
        bus.apb3_addr = '0; bus.apb3_wdata = '0;
        #1;
        check_eq("rst_capt_int", 32'(capt_int), 32'd0);
        check_eq("rst_ready", 32'(bus.apb3_ready), 32'd0);
        check_eq("rst_rdata", 32'(bus.apb3_rdata), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rd_chk("rst_status", 8'h01, 8'hFF, 8'h00);

        // T1: ramp, level trigger on 0x5A, POST_CNT=3
        apb_write(8'h20, 8'hFF);
        apb_write(8'h30, 8'h5A);
        apb_write(8'h02, 8'h03);
        apb_write(8'h00, 8'h01);
        run_probe(120, 32'd0, 1, 1);
        check_eq("t1_capt_int", 32'(capt_int), 32'd1);
        rd_chk("t1_status", 8'h01, 8'hFF, 8'h0F);
        rd_chk("t1_trig_addr", 8'h03, 8'hFF, 8'h0A);
        rd_chk("t1_wr_ptr", 8'h05, 8'hFF, 8'h0E);
        apb_write(8'h04, 8'h0A);
        rd_chk("t1_trig_byte0", 8'h40, 8'hFF, 8'h5A);
        rd_chk("t1_trig_byte1", 8'h41, 8'hFF, 8'h00);
        apb_write(8'h04, 8'h0E);
        rd_chk("t1_oldest", 8'h40, 8'hFF, 8'h4E);
        apb_write(8'h04, 8'h1D);
        rd_chk("t1_rdptr_wrap", 8'h04, 8'hFF, 8'h0D);
        rd_chk("t1_newest", 8'h40, 8'hFF, 8'h5D);
        apb_write(8'h01, 8'h08);
        rd_chk("t1_w1c_status", 8'h01, 8'hFF, 8'h07);
        check_eq("t1_w1c_pin", 32'(capt_int), 32'd0);

        // T4: unmapped read and zero-wait register write
        rd_chk("t4_unmapped", 8'h10, 8'hFF, 8'h00);
        apb_write(8'h02, 8'h07);
        rd_chk("t4_post_cnt", 8'h02, 8'hFF, 8'h07);

        // T2: edge trigger fires once on the first matching qualified sample
        apb_write(8'h30, 8'hA5);
        apb_write(8'h02, 8'h03);
        apb_write(8'h00, 8'h05);
        run_probe(13, 32'd0, 0, 1);
        run_probe(10, 32'hA5, 0, 1);
        rd_chk("t2a_status", 8'h01, 8'hFF, 8'h0F);
        rd_chk("t2a_trig_addr", 8'h03, 8'hFF, 8'h0D);
        rd_chk("t2a_wr_ptr", 8'h05, 8'hFF, 8'h01);
        apb_write(8'h00, 8'h05);
        run_probe(20, 32'hA5, 0, 1);
        rd_chk("t2b_edge_held", 8'h01, 8'hFF, 8'h01);
        apb_write(8'h00, 8'h01);
        run_probe(20, 32'hA5, 0, 1);
        rd_chk("t2c_status", 8'h01, 8'hFF, 8'h0F);
        rd_chk("t2c_trig_addr", 8'h03, 8'hFF, 8'h0C);
        rd_chk("t2c_wr_ptr", 8'h05, 8'hFF, 8'h00);

        // T3: sparse probe_en with FORCE, POST_CNT=0
        apb_write(8'h30, 8'h5A);
        apb_write(8'h02, 8'h00);
        apb_write(8'h00, 8'h01);
        run_probe(8, 32'd0, 0, 4);
        rd_chk("t3_wr_ptr_sparse", 8'h05, 8'hFF, 8'h02);
        apb_write(8'h00, 8'h08);
        rd_chk("t3_force_pending", 8'h01, 8'hFF, 8'h01);
        run_probe(8, 32'hC0, 1, 4);
        rd_chk("t3_status", 8'h01, 8'hFF, 8'h0F);
        rd_chk("t3_trig_addr", 8'h03, 8'hFF, 8'h02);
        rd_chk("t3_wr_ptr", 8'h05, 8'hFF, 8'h03);
        apb_write(8'h04, 8'h02);
        rd_chk("t3_forced_sample", 8'h40, 8'hFF, 8'hC0);

        // T5: ABORT during POST, then ARM+ABORT together
        apb_write(8'h20, 8'h00);
        apb_write(8'h02, 8'h07);
        apb_write(8'h00, 8'h01);
        run_probe(10, 32'd0, 1, 1);
        rd_chk("t5_in_post", 8'h01, 8'h03, 8'h02);
        apb_write(8'h00, 8'h02);
        rd_chk("t5_abort_status", 8'h01, 8'h0B, 8'h00);
        check_eq("t5_abort_pin", 32'(capt_int), 32'd0);
        apb_write(8'h00, 8'h03);
        rd_chk("t5_arm_abort_state", 8'h01, 8'h03, 8'h00);
        rd_chk("t5_arm_abort_wr_ptr", 8'h05, 8'hFF, 8'h0A);

        // T6: asynchronous reset while in POST with two samples left
        apb_write(8'h00, 8'h01);
        run_probe(14, 32'd0, 1, 1);
        rd_chk("t6_pre_reset", 8'h01, 8'h03, 8'h02);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_capt_int", 32'(capt_int), 32'd0);
        check_eq("t6_rst_rdata", 32'(bus.apb3_rdata), 32'd0);
        @(posedge clk); #1;
        check_eq("t6_rst_capt_int_hold", 32'(capt_int), 32'd0);
        reset = 1'b0;
        rd_chk("t6_status", 8'h01, 8'hFF, 8'h00);
        rd_chk("t6_wr_ptr", 8'h05, 8'hFF, 8'h00);
        rd_chk("t6_trig_addr", 8'h03, 8'hFF, 8'h00);
        rd_chk("t6_post_cnt", 8'h02, 8'hFF, 8'h00);
        rd_chk("t6_mask0", 8'h20, 8'hFF, 8'h00);
        rd_chk("t6_rd_ptr", 8'h04, 8'hFF, 8'h00);
        apb_write(8'h00, 8'h01);
        run_probe(20, 32'h33, 0, 1);
        rd_chk("t6_rearm_status", 8'h01, 8'hFF, 8'h0F);
        rd_chk("t6_rearm_trig", 8'h03, 8'hFF, 8'h0F);
        rd_chk("t6_rearm_wr_ptr", 8'h05, 8'hFF, 8'h00);
        check_eq("t6_rearm_pin", 32'(capt_int), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
